muler_ctrl: RTL and testbench

Sequencer between the EXU issue stage and the multi-cycle `muler`. It accepts RISC-V M-extension multiply requests (MUL, MULH, MULHSU, MULHU, MULW) over a valid/ready handshake and drives `muler` with one-cycle `in_valid` pulses. It holds the muler inputs stable for the whole operation, captures the single-cycle `out_valid` result, selects and sign-extends the architectural result, and returns it with its tag. It also handles pipeline flush, including draining an in-flight multiply.

---
 rtl/muler_pkg.sv | 25 ++
 rtl/muler_reuse_cache.sv | 31 +++
 rtl/muler_ctrl.sv | 122 ++++++++++++
 tb/tb_muler_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muler_pkg.sv
// muler_pkg: shared widths, op encodings, FSM states, key type and result select for muler_ctrl
package muler_pkg;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_MULW   = 3'b100
    } mul_op_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} muler_ctrl_state_e;
    localparam logic [1:0] MS_SS = 2'b11;
    localparam logic [1:0] MS_SU = 2'b10;
    localparam logic [1:0] MS_UU = 2'b00;
    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [1:0]      sgn;
        logic            mulw;
    } mul_key_t;
    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op, input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        return op == OP_MUL ? lo : op == OP_MULW ? {{(XLEN-32){lo[31]}}, lo[31:0]} : hi;
    endfunction
endpackage

// File: rtl/muler_reuse_cache.sv
// muler_reuse_cache: one-entry cache of the last muler result keyed by operands and mode
module muler_reuse_cache
    import muler_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  mul_key_t        key,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_hi,
    input  logic [XLEN-1:0] wr_lo,
    output logic            hit,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    mul_key_t key_q;
    logic     valid_q;

    assign hit = valid_q && key_q == key;

    // only the valid bit needs reset; the payload is gated by it
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
            key_q   <= key;
            hi      <= wr_hi;
            lo      <= wr_lo;
        end
    end
endmodule

// File: rtl/muler_ctrl.sv
// muler_ctrl: sequences M-extension multiplies onto muler; optional result reuse under MULER_REUSE_EN
module muler_ctrl #(
    parameter int XLEN  = muler_pkg::XLEN,
    parameter int TAG_W = muler_pkg::TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_src1,
    input  logic [XLEN-1:0]  req_src2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             mul_in_valid,
    output logic             mul_flush,
    output logic             mul_mulw,
    output logic [1:0]       mul_signed,
    output logic [XLEN-1:0]  mul_multiplicand,
    output logic [XLEN-1:0]  mul_multiplier,
    input  logic             mul_out_ready,
    input  logic             mul_out_valid,
    input  logic [XLEN-1:0]  mul_result_hi,
    input  logic [XLEN-1:0]  mul_result_lo
);
    import muler_pkg::*;

    muler_ctrl_state_e state;
    logic [2:0]        op_q;
    mul_key_t          in_key;
    logic              accept, is_w, rsvd, hit;
    logic [XLEN-1:0]   c_hi, c_lo;

    assign req_ready = state == S_IDLE && mul_out_ready && !flush;
    assign accept    = req_valid && req_ready;
    assign mul_flush = flush && (state == S_ISSUE || state == S_WAIT);
    assign is_w      = req_op == OP_MULW;
    assign rsvd      = req_op[2] && |req_op[1:0];
    assign in_key    = mul_key_t'{
        src1: is_w ? {{(XLEN-32){req_src1[31]}}, req_src1[31:0]} : req_src1,
        src2: is_w ? {{(XLEN-32){req_src2[31]}}, req_src2[31:0]} : req_src2,
        sgn:  req_op == OP_MULHU ? MS_UU : req_op == OP_MULHSU ? MS_SU : MS_SS,
        mulw: is_w
    };

`ifdef MULER_REUSE_EN
    mul_key_t cur_key;

    // lookups happen only in IDLE and writes only in WAIT, so one key port is shared
    assign cur_key = state == S_WAIT ? mul_key_t'{src1: mul_multiplicand, src2: mul_multiplier, sgn: mul_signed, mulw: mul_mulw} : in_key;

    muler_reuse_cache u_cache (
        .clock (clock),
        .reset (reset),
        .key   (cur_key),
        .wr_en (state == S_WAIT && mul_out_valid && !flush),
        .wr_hi (mul_result_hi),
        .wr_lo (mul_result_lo),
        .hit   (hit),
        .hi    (c_hi),
        .lo    (c_lo)
    );
`else
    assign hit  = 1'b0;
    assign c_hi = '0;
    assign c_lo = '0;
`endif

    // control FSM; muler operands stay registered from accept until the next accept
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            op_q             <= '0;
            resp_valid       <= 1'b0;
            resp_data        <= '0;
            resp_tag         <= '0;
            mul_in_valid     <= 1'b0;
            mul_mulw         <= 1'b0;
            mul_signed       <= MS_UU;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            mul_in_valid <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    op_q             <= req_op;
                    resp_tag         <= req_tag;
                    mul_multiplicand <= in_key.src1;
                    mul_multiplier   <= in_key.src2;
                    mul_signed       <= in_key.sgn;
                    mul_mulw         <= in_key.mulw;
                    if (rsvd || hit) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= rsvd ? '0 : sel_result(req_op, c_hi, c_lo);
                    end else begin
                        state        <= S_ISSUE;
                        mul_in_valid <= 1'b1;
                    end
                end
                S_ISSUE: state <= flush ? (mul_out_valid ? S_IDLE : S_DRAIN) : S_WAIT;
                S_WAIT: if (flush) begin
                    state <= mul_out_valid ? S_IDLE : S_DRAIN;
                end else if (mul_out_valid) begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= sel_result(op_q, mul_result_hi, mul_result_lo);
                end
                S_RESP: if (flush || resp_ready) begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                end
                S_DRAIN: if (mul_out_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muler_ctrl.sv
// tb_muler_ctrl: directed self-checking bench for muler_ctrl with a 33-cycle muler model
module tb_muler_ctrl;
    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, flush, resp_valid, resp_ready;
    logic [2:0]  req_op;
    logic [63:0] req_src1, req_src2, resp_data;
    logic [4:0]  req_tag, resp_tag;
    logic        mul_in_valid, mul_flush, mul_mulw, mul_out_ready, mov;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand, mul_multiplier;
    logic [127:0] ea, eb, prod;
    int          cnt, pulses, total, bad;

    muler_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_src1         (req_src1),
        .req_src2         (req_src2),
        .req_tag          (req_tag),
        .flush            (flush),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_tag         (resp_tag),
        .mul_in_valid     (mul_in_valid),
        .mul_flush        (mul_flush),
        .mul_mulw         (mul_mulw),
        .mul_signed       (mul_signed),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_out_ready    (mul_out_ready),
        .mul_out_valid    (mov),
        .mul_result_hi    (prod[127:64]),
        .mul_result_lo    (prod[63:0])
    );

    always #5 clock = ~clock;

    // muler model: reads operands every cycle, out_valid 33 cycles after in_valid, ignores flush
    assign ea   = mul_signed[1] ? {{64{mul_multiplicand[63]}}, mul_multiplicand} : {64'b0, mul_multiplicand};
    assign eb   = mul_signed[0] ? {{64{mul_multiplier[63]}}, mul_multiplier} : {64'b0, mul_multiplier};
    assign prod = ea * eb;

    always @(posedge clock) begin
        if (reset) begin
            cnt <= 0;
            mov <= 1'b0;
        end else begin
            mov <= cnt == 1;
            if (mul_in_valid) cnt <= 32;
            else if (cnt != 0) cnt <= cnt - 1;
        end
    end

    always @(posedge clock) if (mul_in_valid) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg);
        req_op = op; req_src1 = a; req_src2 = b; req_tag = tg; req_valid = 1'b1;
        chk("req_ready_before_accept", {63'b0, req_ready}, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic txn(input string nm, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tg, input logic [63:0] exp, input int exp_lat, input int exp_pul);
        int p0, lat;
        p0 = pulses;
        issue(op, a, b, tg);
        wait_resp(lat);
        chk({nm, "_data"}, resp_data, exp);
        chk({nm, "_tag"}, {59'b0, resp_tag}, {59'b0, tg});
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clock); #1;
        chk({nm, "_pulses"}, 64'(pulses - p0), 64'(exp_pul));
        chk({nm, "_resp_drop"}, {63'b0, resp_valid}, 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] s1, s2, sd;
        logic [4:0] st;
        logic bad_rdy, bad_op, seen;
        total = 0; bad = 0; pulses = 0;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
        flush = 1'b0; resp_ready = 1'b1; mul_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_in_valid", {63'b0, mul_in_valid}, 64'd0);
        chk("rst_mul_flush", {63'b0, mul_flush}, 64'd0);
        chk("rst_mulw", {63'b0, mul_mulw}, 64'd0);
        chk("rst_signed", {62'b0, mul_signed}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", {59'b0, resp_tag}, 64'd0);
        chk("rst_mcand", mul_multiplicand, 64'd0);
        chk("rst_mplier", mul_multiplier, 64'd0);
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        mul_out_ready = 1'b0; #1;
        chk("req_ready_follows_mor", {63'b0, req_ready}, 64'd0);
        mul_out_ready = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;

        txn("mul", 3'b000, 64'd3, 64'd5, 5'd7, 64'd15, 34, 1);
        txn("mulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1);
        txn("mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'd1, 34, 1);
        chk("mulhu_signed", {62'b0, mul_signed}, 64'd0);
        txn("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1);
        chk("mulhsu_signed", {62'b0, mul_signed}, 64'd2);
        txn("mulw", 3'b100, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1);
        chk("mulw_mcand_sext", mul_multiplicand, 64'h0000_0000_7FFF_FFFF);
        chk("mulw_flag", {63'b0, mul_mulw}, 64'd1);
        chk("mulw_signed", {62'b0, mul_signed}, 64'd3);

        // flush an in-flight multiply, then drain
        issue(3'b000, 64'h1234, 64'h10, 5'd5);
        repeat (9) begin @(posedge clock); #1; end
        flush = 1'b1; #1;
        chk("flush_mul_flush", {63'b0, mul_flush}, 64'd1);
        chk("flush_req_ready", {63'b0, req_ready}, 64'd0);
        chk("flush_mcand", mul_multiplicand, 64'h1234);
        chk("flush_mplier", mul_multiplier, 64'h10);
        s1 = mul_multiplicand; s2 = mul_multiplier;
        @(posedge clock); #1;
        flush = 1'b0;
        bad_rdy = 1'b0; bad_op = 1'b0; seen = 1'b0; n = 0;
        while (!mov && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (req_ready) bad_rdy = 1'b1;
            if (mul_multiplicand !== s1 || mul_multiplier !== s2 || mul_signed !== 2'b11) bad_op = 1'b1;
            if (resp_valid) seen = 1'b1;
        end
        chk("drain_out_valid_seen", {63'b0, mov}, 64'd1);
        chk("drain_req_ready_low", {63'b0, bad_rdy | req_ready}, 64'd0);
        chk("drain_operands_stable", {63'b0, bad_op}, 64'd0);
        chk("drain_no_resp", {63'b0, seen}, 64'd0);
        @(posedge clock); #1;
        chk("post_drain_ready", {63'b0, req_ready}, 64'd1);
        chk("post_drain_no_resp", {63'b0, resp_valid}, 64'd0);
        txn("mul67", 3'b000, 64'd6, 64'd7, 5'd6, 64'd42, 34, 1);

        // response backpressure
        resp_ready = 1'b0;
        issue(3'b000, 64'd100, 64'd200, 5'd9);
        wait_resp(n);
        chk("bp_lat", 64'(n), 64'd34);
        sd = resp_data; st = resp_tag; bad_op = 1'b0; bad_rdy = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (resp_data !== sd || resp_tag !== st || !resp_valid) bad_op = 1'b1;
            if (req_ready) bad_rdy = 1'b1;
        end
        chk("bp_data", sd, 64'd20000);
        chk("bp_tag", {59'b0, st}, 64'd9);
        chk("bp_hold", {63'b0, bad_op}, 64'd0);
        chk("bp_req_ready", {63'b0, bad_rdy}, 64'd0);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release", {63'b0, resp_valid}, 64'd0);

        // reserved op and flush of a pending response
        txn("rsvd", 3'b111, 64'd9, 64'd9, 5'h1F, 64'd0, 0, 0);
        resp_ready = 1'b0;
        issue(3'b101, 64'd1, 64'd1, 5'd8);
        chk("rsvd2_valid", {63'b0, resp_valid}, 64'd1);
        flush = 1'b1;
        @(posedge clock); #1;
        chk("resp_flush_drop", {63'b0, resp_valid}, 64'd0);
        chk("idle_flush_no_ready", {63'b0, req_ready}, 64'd0);
        flush = 1'b0; resp_ready = 1'b1; #1;
        chk("idle_ready_back", {63'b0, req_ready}, 64'd1);

        // reuse of a previous result with the same operands
        txn("reuse_mulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1);
`ifdef MULER_REUSE_EN
        txn("reuse_mul", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
`else
        txn("reuse_mul", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
